// File: rtl/board_io_pkg.sv
// Shared types and helpers for the board user-I/O block.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package board_io_pkg;

  // Default PWM resolution used by the package-level duty view.
  localparam int PWM_BITS_DEF = 8;

  // Channel ordinals inside one RGB LED. Packing is {r,g,b}, so r is the
  // most significant field of each LED's slice.
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int N_CH = 3;

  // One LED's duty triple at the default resolution.
  typedef struct packed {
    logic [PWM_BITS_DEF-1:0] r;
    logic [PWM_BITS_DEF-1:0] g;
    logic [PWM_BITS_DEF-1:0] b;
  } rgb_duty_t;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit offset of a channel within the flat {led}{r,g,b} channel vector.
  function automatic int ch_index(input int led, input int ch);
    return led * N_CH + (N_CH - 1 - ch);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchroniser plus counting debouncer for one asynchronous input bit.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from raw edge to level change.
// Backpressure: none; free-running filter.
// Ports: clk, reset_n (sync, active-low), raw (async pin),
//        level (debounced state), rise (registered 1-cycle pulse on 0->1),
//        rise_next (rise one cycle early, for same-cycle state kept by the parent).
module debounce_filter
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic rise_next
);

  localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_bit == stable_q) begin
      // Any agreement restarts the count, so a mismatch must be contiguous.
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      stable_d = sync_bit;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign level     = stable_q;
  assign rise      = rise_q;
  assign rise_next = rise_d;

endmodule

// File: rtl/board_io_ctrl.sv
// Board user-I/O: debounced buttons/switches with press pulses and toggles,
// PWM-dimmed RGB LEDs and gated plain LEDs.
// Latency: inputs SYNC_STAGES+DEBOUNCE_CYCLES clocks; LED outputs 1 clock.
// Backpressure: none; all outputs registered, free-running.
// Ports: btn_raw/sw_raw (async pins) -> btn_level/btn_press/btn_toggle/sw_level;
//        rgb_duty {led}{r,g,b}, mono_on, led_enable -> led_rgb {led}{r,g,b}, led_mono.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int N_RGB           = 4,
  parameter int N_MONO          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int PWM_BITS        = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_BTN-1:0]              btn_raw,
  input  logic [N_SW-1:0]               sw_raw,
  output logic [N_BTN-1:0]              btn_level,
  output logic [N_BTN-1:0]              btn_press,
  output logic [N_BTN-1:0]              btn_toggle,
  output logic [N_SW-1:0]               sw_level,
  input  logic [N_RGB*N_CH*PWM_BITS-1:0] rgb_duty,
  input  logic [N_MONO-1:0]             mono_on,
  input  logic                          led_enable,
  output logic [N_RGB*N_CH-1:0]         led_rgb,
  output logic [N_MONO-1:0]             led_mono
);

  // ---------------------------------------------------------------------
  // Buttons and switches
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] btn_rise_next;
  logic [N_BTN-1:0] toggle_q, toggle_d;
  logic [N_SW-1:0]  sw_rise_unused;
  logic [N_SW-1:0]  sw_rise_next_unused;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (btn_raw[i]),
      .level    (btn_level[i]),
      .rise     (btn_press[i]),
      .rise_next(btn_rise_next[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (sw_raw[i]),
      .level    (sw_level[i]),
      .rise     (sw_rise_unused[i]),
      .rise_next(sw_rise_next_unused[i])
    );
  end

  // Toggle flips on the early rise indication so it lands on the same
  // edge as the registered press pulse.
  assign toggle_d = toggle_q ^ btn_rise_next;

  // ---------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------
  localparam int NCHAN = N_RGB * N_CH;

  logic [PWM_BITS-1:0]       pwm_q, pwm_d;
  logic [NCHAN*PWM_BITS-1:0] shadow_q, shadow_d;
  logic [NCHAN-1:0]          rgb_q, rgb_d;
  logic [N_MONO-1:0]         mono_q, mono_d;

  always_comb begin
    pwm_d    = pwm_q + 1'b1;
    // New duties are taken only across the period boundary, so the
    // period that starts on this edge already compares against them.
    shadow_d = (pwm_q == '1) ? rgb_duty : shadow_q;
    rgb_d    = '0;
    for (int l = 0; l < N_RGB; l++) begin
      for (int c = CH_R; c <= CH_B; c++) begin
        rgb_d[ch_index(l, c)] =
          (pwm_d < shadow_d[ch_index(l, c)*PWM_BITS +: PWM_BITS]) & led_enable;
      end
    end
    mono_d = mono_on & {N_MONO{led_enable}};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      toggle_q <= '0;
      pwm_q    <= '0;
      shadow_q <= '0;
      rgb_q    <= '0;
      mono_q   <= '0;
    end else begin
      toggle_q <= toggle_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      rgb_q    <= rgb_d;
      mono_q   <= mono_d;
    end
  end

  assign btn_toggle = toggle_q;
  assign led_rgb    = rgb_q;
  assign led_mono   = mono_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
module tb_board_io_ctrl;

  localparam int N_BTN = 4;
  localparam int N_SW = 4;
  localparam int N_RGB = 4;
  localparam int N_MONO = 4;
  localparam int SYNC = 2;
  localparam int DB = 8;
  localparam int PW = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [N_BTN-1:0]         btn_raw;
  logic [N_SW-1:0]          sw_raw;
  logic [N_BTN-1:0]         btn_level, btn_press, btn_toggle;
  logic [N_SW-1:0]          sw_level;
  logic [N_RGB*3*PW-1:0]    rgb_duty;
  logic [N_MONO-1:0]        mono_on;
  logic                     led_enable;
  logic [N_RGB*3-1:0]       led_rgb;
  logic [N_MONO-1:0]        led_mono;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .N_BTN(N_BTN), .N_SW(N_SW), .N_RGB(N_RGB), .N_MONO(N_MONO),
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_toggle(btn_toggle),
    .sw_level(sw_level), .rgb_duty(rgb_duty), .mono_on(mono_on),
    .led_enable(led_enable), .led_rgb(led_rgb), .led_mono(led_mono)
  );

  // Period phase reference: counts clocks since reset release, mod 16.
  logic [PW-1:0] phase;
  always @(posedge clk) begin
    if (!reset_n) phase <= '0;
    else          phase <= phase + 1'b1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // btn[2] stimulus: high 12, low 12, high 12, then low.
  function automatic logic raw2(input int j);
    return (j >= 0) && ((j < 12) || (j >= 24 && j < 36));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=done");
    $fatal(1);
  end

  initial begin
    logic tgl_exp;
    logic pr_exp;
    int   presses;
    int   wraps;
    logic found;

    reset_n = 1'b0; btn_raw = '0; sw_raw = '0; rgb_duty = '0;
    mono_on = '0; led_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_btn_level",  btn_level,  0);
    chk_eq("rst_btn_press",  btn_press,  0);
    chk_eq("rst_btn_toggle", btn_toggle, 0);
    chk_eq("rst_sw_level",   sw_level,   0);
    chk_eq("rst_led_rgb",    led_rgb,    0);
    chk_eq("rst_led_mono",   led_mono,   0);
    reset_n = 1'b1;

    // Clean press on btn0 and switch0: accepted 10 clocks after the edge.
    @(negedge clk);
    btn_raw[0] = 1'b1; sw_raw[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk_eq("b0_level",  btn_level[0],  k >= 10);
      chk_eq("b0_press",  btn_press[0],  k == 10);
      chk_eq("b0_toggle", btn_toggle[0], k >= 10);
      chk_eq("sw0_level", sw_level[0],   k >= 10);
    end

    // 7-cycle glitch on btn1 is never accepted.
    for (int t = 0; t < 20; t++) begin
      btn_raw[1] = (t < 7);
      @(negedge clk);
      chk_eq("b1_level",  btn_level[1],  0);
      chk_eq("b1_press",  btn_press[1],  0);
      chk_eq("b1_toggle", btn_toggle[1], 0);
    end

    // Two accepted presses on btn2; releases give no pulse.
    tgl_exp = 1'b0; presses = 0;
    for (int t = 0; t < 60; t++) begin
      btn_raw[2] = raw2(t);
      @(negedge clk);
      pr_exp  = raw2(t + 1 - 10) & ~raw2(t + 1 - 11);
      tgl_exp = tgl_exp ^ pr_exp;
      chk_eq("b2_level",  btn_level[2],  raw2(t + 1 - 10));
      chk_eq("b2_press",  btn_press[2],  pr_exp);
      chk_eq("b2_toggle", btn_toggle[2], tgl_exp);
      if (btn_press[2]) presses++;
    end
    chk_eq("b2_press_count", presses, 2);
    chk_eq("b2_toggle_end",  btn_toggle[2], 0);

    // PWM: led0 r=5 g=0 b=15.
    rgb_duty[11:0] = {4'd5, 4'd0, 4'd15};
    led_enable = 1'b1;
    mono_on = 4'b1010;
    wraps = 0; found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      @(negedge clk);
      if (phase == 4'd15) wraps++;
      if (wraps == 2) found = 1'b1;
    end
    chk_eq("pwm_sync", found, 1);
    chk_eq("mono_on", led_mono, 4'b1010);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_eq("pwm_r5",  led_rgb[2], i < 5);
      chk_eq("pwm_g0",  led_rgb[1], 0);
      chk_eq("pwm_b15", led_rgb[0], i < 15);
    end
    // Duty change at P=3 only applies from the next period.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_eq("pwm_r5_mid", led_rgb[2], i < 5);
      if (i == 3) rgb_duty[11:8] = 4'd12;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_eq("pwm_r12", led_rgb[2], i < 12);
    end

    // Reset mid-debounce (C=6) and mid-period.
    btn_raw[3] = 1'b1;
    repeat (8) @(negedge clk);
    chk_eq("pre_rst_r_on", led_rgb[2], 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_eq("mid_rst_btn_level",  btn_level,  0);
    chk_eq("mid_rst_btn_press",  btn_press,  0);
    chk_eq("mid_rst_btn_toggle", btn_toggle, 0);
    chk_eq("mid_rst_sw_level",   sw_level,   0);
    chk_eq("mid_rst_led_rgb",    led_rgb,    0);
    chk_eq("mid_rst_led_mono",   led_mono,   0);
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk_eq("post_rst_level", btn_level, (k >= 10) ? 4'b1001 : 4'b0000);
      chk_eq("post_rst_press", btn_press, (k == 10) ? 4'b1001 : 4'b0000);
      chk_eq("post_rst_rgb",   led_rgb[2:0], (k == 16) ? 3'b101 : 3'b000);
      chk_eq("post_rst_mono",  led_mono, 4'b1010);
    end

    // Global gate forces all LEDs off within one clock; counter keeps running.
    led_enable = 1'b0;
    @(negedge clk);
    chk_eq("gate_rgb",  led_rgb,  0);
    chk_eq("gate_mono", led_mono, 0);
    led_enable = 1'b1;
    @(negedge clk);
    chk_eq("regate_rgb",  led_rgb[2:0], 3'b101);
    chk_eq("regate_mono", led_mono, 4'b1010);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
